// File: rtl/alu4_pkg.sv
// Shared definitions for the alu4 issue/writeback front end: op codes,
// flag bit positions inside the {c,n,z,v} flags word, and FSM states.
package alu4_pkg;

    localparam logic [2:0] OP_NOTA = 3'b000;
    localparam logic [2:0] OP_NOTB = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_ADD  = 3'b110;
    localparam logic [2:0] OP_SUB  = 3'b111;

    // flags word is {c,n,z,v}
    localparam int FLAG_V = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_WB   = 2'b10
    } state_t;

endpackage

// File: rtl/alu4.sv
// Combinational 4-bit ALU. Carry on subtract means "no borrow" (a >= b
// unsigned); overflow is two's-complement overflow for add/sub and zero
// for logic ops.
module alu4
    import alu4_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [2:0] op,
    output logic [3:0] result,
    output logic       c,
    output logic       n,
    output logic       z,
    output logic       v
);

    logic [4:0] sum;
    logic [4:0] dif;

    assign sum = {1'b0, a} + {1'b0, b};
    assign dif = {1'b0, a} + {1'b0, ~b} + 5'd1;

    // operation select and flag generation
    always_comb begin
        result = 4'd0;
        c      = 1'b0;
        v      = 1'b0;
        case (op)
            OP_NOTA: result = ~a;
            OP_NOTB: result = ~b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_XNOR: result = ~(a ^ b);
            OP_ADD: begin
                result = sum[3:0];
                c      = sum[4];
                v      = (a[3] == b[3]) && (sum[3] != a[3]);
            end
            OP_SUB: begin
                result = dif[3:0];
                c      = dif[4];
                v      = (a[3] != b[3]) && (dif[3] != a[3]);
            end
            default: result = 4'd0;
        endcase
        n = result[3];
        z = (result == 4'd0);
    end

endmodule

// File: rtl/regfile_1w2r.sv
// Small register file: two operand read ports plus an observation port,
// all combinational. Writes come from the ALU writeback and from the
// direct load strobe; when both target the same entry the writeback wins
// and the load is reported as lost.
module regfile_1w2r #(
    parameter int DATA_W = 4,
    parameter int NREG   = 4,
    parameter int AW     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ld_en,
    input  logic [AW-1:0]     ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [AW-1:0]     ra_addr,
    input  logic [AW-1:0]     rb_addr,
    input  logic [AW-1:0]     obs_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    output logic [DATA_W-1:0] obs_data,
    output logic              ld_lost
);

    logic [DATA_W-1:0] regs [NREG];

    // per-entry write: writeback has priority over a load to the same entry
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wb_en && (wb_addr == AW'(i))) begin
                    regs[i] <= wb_data;
                end else if (ld_en && (ld_addr == AW'(i))) begin
                    regs[i] <= ld_data;
                end
            end
        end
    end

    assign ra_data  = regs[ra_addr];
    assign rb_data  = regs[rb_addr];
    assign obs_data = regs[obs_addr];
    assign ld_lost  = ld_en && wb_en && (ld_addr == wb_addr);

endmodule

// File: rtl/alu4_issue.sv
// Issue/writeback front end for alu4. One instruction is accepted in IDLE,
// its operands are registered onto the ALU ports for the EXEC cycle, the
// ALU result and flags are written back at the end of EXEC, and done
// pulses during the following WB cycle.
module alu4_issue
    import alu4_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int NREG   = 4,
    parameter int AW     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [AW-1:0]     in_rd,
    input  logic [AW-1:0]     in_ra,
    input  logic [AW-1:0]     in_rb,
    input  logic              ld_en,
    input  logic [AW-1:0]     ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_drop,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_c,
    input  logic              alu_n,
    input  logic              alu_z,
    input  logic              alu_v,
    output logic              done,
    output logic [DATA_W-1:0] res,
    output logic [3:0]        flags,
    input  logic [AW-1:0]     obs_addr,
    output logic [DATA_W-1:0] obs_data
);

    state_t            state;
    state_t            next_state;
    logic              accept;
    logic              wb_en;
    logic              ld_lost;
    logic [AW-1:0]     rd_p0;
    logic [DATA_W-1:0] ra_data;
    logic [DATA_W-1:0] rb_data;

    assign accept = in_valid && in_ready;

    regfile_1w2r #(
        .DATA_W (DATA_W),
        .NREG   (NREG),
        .AW     (AW)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .wb_en    (wb_en),
        .wb_addr  (rd_p0),
        .wb_data  (alu_result),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .ra_addr  (in_ra),
        .rb_addr  (in_rb),
        .obs_addr (obs_addr),
        .ra_data  (ra_data),
        .rb_data  (rb_data),
        .obs_data (obs_data),
        .ld_lost  (ld_lost)
    );

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // next state and per-state control strobes
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        wb_en      = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                wb_en      = 1'b1;
                next_state = S_WB;
            end
            S_WB: begin
                done       = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // operand capture at issue, result/flags capture at writeback
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_p0   <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_op  <= OP_NOTA;
            res     <= '0;
            flags   <= 4'b0000;
            ld_drop <= 1'b0;
        end else begin
            // stage 0: issue
            if (accept) begin
                rd_p0  <= in_rd;
                alu_a  <= ra_data;
                alu_b  <= rb_data;
                alu_op <= in_op;
            end
            // stage 1: writeback
            if (wb_en) begin
                res           <= alu_result;
                flags[FLAG_C] <= alu_c;
                flags[FLAG_N] <= alu_n;
                flags[FLAG_Z] <= alu_z;
                flags[FLAG_V] <= alu_v;
            end
            ld_drop <= ld_lost;
        end
    end

endmodule

// File: tb/tb_alu4_issue.sv
// Self-checking bench for alu4_issue driving a real alu4 instance.
module tb_alu4_issue;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_op;
    logic [1:0] in_rd, in_ra, in_rb;
    logic       ld_en;
    logic [1:0] ld_addr;
    logic [3:0] ld_data;
    logic       ld_drop;
    logic [3:0] alu_a, alu_b;
    logic [2:0] alu_op;
    logic [3:0] alu_result;
    logic       alu_c, alu_n, alu_z, alu_v;
    logic       done;
    logic [3:0] res;
    logic [3:0] flags;
    logic [1:0] obs_addr;
    logic [3:0] obs_data;

    int errors = 0;
    int checks = 0;
    int mr [4];

    always #5 clk = ~clk;

    alu4_issue #(.DATA_W(4), .NREG(4), .AW(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_ra(in_ra), .in_rb(in_rb),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_drop(ld_drop),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_c(alu_c), .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v),
        .done(done), .res(res), .flags(flags), .obs_addr(obs_addr), .obs_data(obs_data)
    );

    alu4 u_alu (
        .a(alu_a), .b(alu_b), .op(alu_op), .result(alu_result),
        .c(alu_c), .n(alu_n), .z(alu_z), .v(alu_v)
    );

    typedef struct {
        logic [2:0] op;
        logic [1:0] rd, ra, rb;
        logic [3:0] a_val, b_val;
        logic [3:0] exp_res;
        logic [3:0] exp_flags;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // reference ALU from arithmetic on plain integers
    function automatic void model_alu(input int op, input int a, input int b,
                                      output int r, output int fl);
        int sa, sb, s, c, v;
        sa = (a > 7) ? a - 16 : a;
        sb = (b > 7) ? b - 16 : b;
        c = 0; v = 0;
        case (op)
            0: r = 15 - a;
            1: r = 15 - b;
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = 15 - (a ^ b);
            6: begin
                r = (a + b) % 16; c = (a + b > 15) ? 1 : 0;
                s = sa + sb; v = (s > 7 || s < -8) ? 1 : 0;
            end
            default: begin
                r = (a - b + 16) % 16; c = (a >= b) ? 1 : 0;
                s = sa - sb; v = (s > 7 || s < -8) ? 1 : 0;
            end
        endcase
        fl = c * 8 + ((r >= 8) ? 4 : 0) + ((r == 0) ? 2 : 0) + v;
    endfunction

    task automatic read_reg(input int i, output int val);
        obs_addr = 2'(i);
        #1;
        val = int'(obs_data);
    endtask

    task automatic check_regs(input string tag);
        int val;
        for (int i = 0; i < 4; i++) begin
            read_reg(i, val);
            chk($sformatf("%s_R%0d", tag, i), val, mr[i]);
        end
    endtask

    task automatic do_load(input int addr, input int data);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = 2'(addr); ld_data = 4'(data);
        @(negedge clk);
        ld_en = 1'b0;
        mr[addr] = data;
    endtask

    // Issue one instruction and wait for done. ld_mode 1 = load in the
    // handshake cycle, 2 = load during EXEC. Returns at the negedge of the
    // done cycle.
    task automatic run_instr(input int op, input int rd, input int ra, input int rb,
                             input int ld_mode, input int la, input int ldat,
                             output int lat, output int drop_seen);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) chk("ready_timeout", 0, 1);
        in_valid = 1'b1;
        in_op = 3'(op); in_rd = 2'(rd); in_ra = 2'(ra); in_rb = 2'(rb);
        if (ld_mode == 1) begin
            ld_en = 1'b1; ld_addr = 2'(la); ld_data = 4'(ldat);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ld_en = 1'b0;
        lat = 0;
        drop_seen = 0;
        while (!done && lat < 10) begin
            @(negedge clk);
            lat++;
            if (ld_drop) drop_seen = 1;
            ld_en = 1'b0;
            if (lat == 1 && ld_mode == 2 && !done) begin
                ld_en = 1'b1; ld_addr = 2'(la); ld_data = 4'(ldat);
            end
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    // run an instruction and check it against the reference model
    task automatic model_instr(input string tag, input int op, input int rd, input int ra,
                               input int rb, input int ld_mode, input int la, input int ldat);
        int er, ef, lat, drop, a, b, edrop;
        a = mr[ra]; b = mr[rb];
        model_alu(op, a, b, er, ef);
        edrop = (ld_mode == 2 && la == rd) ? 1 : 0;
        run_instr(op, rd, ra, rb, ld_mode, la, ldat, lat, drop);
        if (ld_mode == 1 || (ld_mode == 2 && la != rd)) mr[la] = ldat;
        mr[rd] = er;
        chk({tag, "_lat"}, lat, 2);
        chk({tag, "_res"}, int'(res), er);
        chk({tag, "_flags"}, int'(flags), ef);
        @(negedge clk);
        if (ld_drop) drop = 1;
        chk({tag, "_drop"}, drop, edrop);
        check_regs(tag);
    endtask

    initial begin
        int lat, drop, val, cnt;

        vecs[0]  = '{3'b110, 2'd2, 2'd0, 2'd1, 4'h5, 4'h3, 4'h8, 4'b0101};
        vecs[1]  = '{3'b111, 2'd3, 2'd1, 2'd1, 4'h3, 4'h3, 4'h0, 4'b1010};
        vecs[2]  = '{3'b000, 2'd2, 2'd0, 2'd1, 4'hA, 4'h3, 4'h5, 4'b0000};
        vecs[3]  = '{3'b001, 2'd2, 2'd0, 2'd1, 4'h6, 4'h0, 4'hF, 4'b0100};
        vecs[4]  = '{3'b010, 2'd2, 2'd0, 2'd1, 4'hC, 4'hA, 4'h8, 4'b0100};
        vecs[5]  = '{3'b011, 2'd2, 2'd0, 2'd1, 4'h0, 4'h0, 4'h0, 4'b0010};
        vecs[6]  = '{3'b100, 2'd2, 2'd0, 2'd1, 4'hF, 4'hF, 4'h0, 4'b0010};
        vecs[7]  = '{3'b101, 2'd2, 2'd0, 2'd1, 4'h5, 4'hA, 4'h0, 4'b0010};
        vecs[8]  = '{3'b110, 2'd2, 2'd0, 2'd1, 4'hF, 4'h1, 4'h0, 4'b1010};
        vecs[9]  = '{3'b111, 2'd2, 2'd0, 2'd1, 4'h0, 4'h1, 4'hF, 4'b0100};
        vecs[10] = '{3'b111, 2'd2, 2'd0, 2'd1, 4'h8, 4'h1, 4'h7, 4'b1001};
        vecs[11] = '{3'b110, 2'd3, 2'd2, 2'd0, 4'h7, 4'h1, 4'h8, 4'b0101};

        reset = 1'b1; in_valid = 1'b0; in_op = 3'd0; in_rd = 2'd0; in_ra = 2'd0; in_rb = 2'd0;
        ld_en = 1'b0; ld_addr = 2'd0; ld_data = 4'd0; obs_addr = 2'd0;
        for (int i = 0; i < 4; i++) mr[i] = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", int'(in_ready), 1);
        chk("rst_done", int'(done), 0);
        chk("rst_res", int'(res), 0);
        chk("rst_flags", int'(flags), 0);
        chk("rst_drop", int'(ld_drop), 0);
        chk("rst_aluop", int'(alu_op), 0);
        check_regs("rst");

        // directed table
        for (int i = 0; i < 12; i++) begin
            do_load(vecs[i].ra, vecs[i].a_val);
            do_load(vecs[i].rb, vecs[i].b_val);
            run_instr(vecs[i].op, vecs[i].rd, vecs[i].ra, vecs[i].rb, 0, 0, 0, lat, drop);
            mr[vecs[i].rd] = vecs[i].exp_res;
            chk($sformatf("vec%0d_lat", i), lat, 2);
            chk($sformatf("vec%0d_res", i), int'(res), int'(vecs[i].exp_res));
            chk($sformatf("vec%0d_flags", i), int'(flags), int'(vecs[i].exp_flags));
            read_reg(vecs[i].rd, val);
            chk($sformatf("vec%0d_rd", i), val, int'(vecs[i].exp_res));
            read_reg(vecs[i].ra, val);
            chk($sformatf("vec%0d_ra_kept", i), val, mr[vecs[i].ra]);
        end

        // load into ra during the handshake cycle: operand uses old value
        do_load(0, 5); do_load(1, 3);
        run_instr(6, 2, 0, 1, 1, 0, 1, lat, drop);
        chk("hs_load_res", int'(res), 8);
        read_reg(0, val);
        chk("hs_load_r0", val, 1);
        mr[0] = 1; mr[2] = 8;

        // two queued instructions with in_valid held high
        do_load(0, 5); do_load(1, 3);
        @(negedge clk);
        in_valid = 1'b1; in_op = 3'b110; in_rd = 2'd2; in_ra = 2'd0; in_rb = 2'd1;
        @(posedge clk);
        #1 in_op = 3'b111; in_rd = 2'd3; in_ra = 2'd2; in_rb = 2'd1;
        @(negedge clk);
        chk("q_ready_exec", int'(in_ready), 0);
        @(negedge clk);
        chk("q_ready_wb", int'(in_ready), 0);
        chk("q_done1", int'(done), 1);
        chk("q_res1", int'(res), 8);
        @(negedge clk);
        chk("q_ready_idle", int'(in_ready), 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) begin
                cnt++;
                chk("q_res2", int'(res), 5);
                chk("q_flags2", int'(flags), 4'b1001);
            end
        end
        chk("q_done2_count", cnt, 1);
        mr[2] = 8; mr[3] = 5;
        check_regs("q");

        // load collision with writeback address, then to another address
        do_load(0, 5); do_load(1, 3);
        model_instr("coll_rd", 6, 2, 0, 1, 2, 2, 15);
        model_instr("coll_r0", 6, 2, 0, 1, 2, 0, 15);

        // xor of a register with itself, observed right after writeback
        do_load(0, 10);
        run_instr(4, 0, 0, 0, 0, 0, 0, lat, drop);
        read_reg(0, val);
        chk("xor_obs", val, 0);
        chk("xor_flags", int'(flags), 4'b0010);
        mr[0] = 0;

        // randomized instructions against the model
        for (int k = 0; k < 120; k++) begin
            int op, rd, ra, rb, mode, la, ldat;
            op = int'($urandom_range(0, 7));
            rd = int'($urandom_range(0, 3));
            ra = int'($urandom_range(0, 3));
            rb = int'($urandom_range(0, 3));
            mode = int'($urandom_range(0, 2));
            la = int'($urandom_range(0, 3));
            ldat = int'($urandom_range(0, 15));
            if (k % 10 == 0) do_load(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
            model_instr($sformatf("rnd%0d", k), op, rd, ra, rb, mode, la, ldat);
        end

        // reset during EXEC abandons the instruction
        do_load(0, 7); do_load(1, 2);
        @(negedge clk);
        in_valid = 1'b1; in_op = 3'b110; in_rd = 2'd3; in_ra = 2'd0; in_rb = 2'd1;
        @(posedge clk);
        #1 in_valid = 1'b0; reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("mrst_ready", int'(in_ready), 1);
        chk("mrst_flags", int'(flags), 0);
        chk("mrst_res", int'(res), 0);
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk("mrst_no_done", cnt, 0);
        for (int i = 0; i < 4; i++) mr[i] = 0;
        check_regs("mrst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
